// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths and types for the 16 x 16-bit CPU register file
package reg_file_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - combinational read mux; write-through forwarding when REG_FILE_BYPASS_EN is defined
module reg_file_rd_port
    import reg_file_pkg::*;
(
    input  reg_data_t regs_i [NUM_REGS],
    input  reg_addr_t ra_i,
    input  logic      rst_n_i,
`ifdef REG_FILE_BYPASS_EN
    input  logic      wr_en_i,
    input  reg_addr_t wa_i,
    input  reg_data_t wd_i,
`endif
    output reg_data_t rd_o
);

    always_comb begin
        rd_o = regs_i[ra_i];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en_i && (wa_i == ra_i)) begin
            rd_o = wd_i;
        end
`endif
        // Forwarded data must not leak out while the file is held in reset.
        if (!rst_n_i) begin
            rd_o = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 16 x 16-bit register file, two async read ports, one sync write port
// Optional write-through forwarding on the read ports: REG_FILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  reg_addr_t RA1,
    input  reg_addr_t RA2,
    input  reg_addr_t WA,
    input  reg_data_t data_in,
    input  logic      write_enable,
    output reg_data_t data_out1,
    output reg_data_t data_out2
);

    reg_data_t regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_enable) begin
            regs_q[WA] <= data_in;
        end
    end

    reg_file_rd_port u_rd_port1 (
        .regs_i  (regs_q),
        .ra_i    (RA1),
        .rst_n_i (reset),
`ifdef REG_FILE_BYPASS_EN
        .wr_en_i (write_enable),
        .wa_i    (WA),
        .wd_i    (data_in),
`endif
        .rd_o    (data_out1)
    );

    reg_file_rd_port u_rd_port2 (
        .regs_i  (regs_q),
        .ra_i    (RA2),
        .rst_n_i (reset),
`ifdef REG_FILE_BYPASS_EN
        .wr_en_i (write_enable),
        .wa_i    (WA),
        .wd_i    (data_in),
`endif
        .rd_o    (data_out2)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file (REG_FILE_BYPASS_EN aware)
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [3:0]  RA1;
    logic [3:0]  RA2;
    logic [3:0]  WA;
    logic [15:0] data_in;
    logic        write_enable;
    logic [15:0] data_out1;
    logic [15:0] data_out2;

    int tests_run;
    int tests_failed;

    reg_file dut (
        .clk          (clk),
        .reset        (reset),
        .RA1          (RA1),
        .RA2          (RA2),
        .WA           (WA),
        .data_in      (data_in),
        .write_enable (write_enable),
        .data_out1    (data_out1),
        .data_out2    (data_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_reg(input logic [3:0] addr, input logic [15:0] val);
        @(negedge clk);
        write_enable = 1'b1;
        WA           = addr;
        data_in      = val;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset        = 1'b0;
        write_enable = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            RA1 = 4'(i);
            RA2 = 4'(15 - i);
            #1;
            tests_run += 2;
            if (data_out1 !== 16'h0000) begin
                tests_failed++;
                $display("FAIL reset_rd1[%0d]: got %h expected 0000", i, data_out1);
            end
            if (data_out2 !== 16'h0000) begin
                tests_failed++;
                $display("FAIL reset_rd2[%0d]: got %h expected 0000", 15 - i, data_out2);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_gated_write();
        @(negedge clk);
        write_enable = 1'b0;
        WA           = 4'd8;
        data_in      = 16'h8A37;
        RA1          = 4'd8;
        @(posedge clk);
        #1;
        tests_run++;
        if (data_out1 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL gated_write: got %h expected 0000", data_out1);
        end
    endtask

    task automatic test_write_read();
        write_reg(4'd8, 16'h8A37);
        write_reg(4'd15, 16'hF486);
        RA1 = 4'd8;
        RA2 = 4'd15;
        #1;
        tests_run += 2;
        if (data_out1 !== 16'h8A37) begin
            tests_failed++;
            $display("FAIL write_read_r8: got %h expected 8a37", data_out1);
        end
        if (data_out2 !== 16'hF486) begin
            tests_failed++;
            $display("FAIL write_read_r15: got %h expected f486", data_out2);
        end
        RA1 = 4'd0;
        RA2 = 4'd1;
        #1;
        tests_run += 2;
        if (data_out1 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL write_read_r0: got %h expected 0000", data_out1);
        end
        if (data_out2 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL write_read_r1: got %h expected 0000", data_out2);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        write_enable = 1'b0;
        WA           = 4'd15;
        data_in      = 16'h0104;
        RA1          = 4'd15;
        RA2          = 4'd5;
        @(posedge clk);
        #1;
        tests_run += 2;
        if (data_out1 !== 16'hF486) begin
            tests_failed++;
            $display("FAIL hold_r15: got %h expected f486", data_out1);
        end
        if (data_out2 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL hold_r5: got %h expected 0000", data_out2);
        end
    endtask

    task automatic test_dual_write();
        write_reg(4'd8, 16'h80D2);
        write_reg(4'd15, 16'h80D2);
        RA1 = 4'd8;
        RA2 = 4'd15;
        #1;
        tests_run += 2;
        if (data_out1 !== 16'h80D2) begin
            tests_failed++;
            $display("FAIL dual_r8: got %h expected 80d2", data_out1);
        end
        if (data_out2 !== 16'h80D2) begin
            tests_failed++;
            $display("FAIL dual_r15: got %h expected 80d2", data_out2);
        end
        // Assert reset between edges; the next posedge is still >2 time units away.
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        tests_run += 2;
        if (data_out1 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_reset_rd1: got %h expected 0000", data_out1);
        end
        if (data_out2 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_reset_rd2: got %h expected 0000", data_out2);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_wins();
        write_reg(4'd2, 16'h5A5A);
        @(negedge clk);
        reset        = 1'b0;
        write_enable = 1'b1;
        WA           = 4'd2;
        data_in      = 16'hFFFF;
        RA1          = 4'd2;
        RA2          = 4'd2;
        @(posedge clk);
        #1;
        tests_run++;
        if (data_out1 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_wins_out: got %h expected 0000", data_out1);
        end
        @(negedge clk);
        write_enable = 1'b0;
        reset        = 1'b1;
        #1;
        tests_run++;
        if (data_out2 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_wins_stored: got %h expected 0000", data_out2);
        end
    endtask

    task automatic test_same_cycle();
        logic [15:0] exp_pre;
        write_reg(4'd3, 16'h1111);
        @(negedge clk);
        write_enable = 1'b1;
        WA           = 4'd3;
        data_in      = 16'h1234;
        RA1          = 4'd3;
        RA2          = 4'd4;
`ifdef REG_FILE_BYPASS_EN
        exp_pre = 16'h1234;
`else
        exp_pre = 16'h1111;
`endif
        #1;
        tests_run += 2;
        if (data_out1 !== exp_pre) begin
            tests_failed++;
            $display("FAIL pre_edge_r3: got %h expected %h", data_out1, exp_pre);
        end
        if (data_out2 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL pre_edge_r4: got %h expected 0000", data_out2);
        end
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        #1;
        tests_run++;
        if (data_out1 !== 16'h1234) begin
            tests_failed++;
            $display("FAIL post_edge_r3: got %h expected 1234", data_out1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) begin
            write_reg(4'(i), 16'hC000 + 16'(i * 16'h0111));
        end
        for (int i = 0; i < 16; i++) begin
            exp = 16'hC000 + 16'(i * 16'h0111);
            RA1 = 4'(i);
            RA2 = 4'(i);
            #1;
            tests_run += 2;
            if (data_out1 !== exp) begin
                tests_failed++;
                $display("FAIL b2b_rd1[%0d]: got %h expected %h", i, data_out1, exp);
            end
            if (data_out2 !== exp) begin
                tests_failed++;
                $display("FAIL b2b_rd2[%0d]: got %h expected %h", i, data_out2, exp);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        RA1          = '0;
        RA2          = '0;
        WA           = '0;
        data_in      = '0;
        write_enable = 1'b0;

        test_reset();
        test_gated_write();
        test_write_read();
        test_hold();
        test_dual_write();
        test_reset_wins();
        test_same_cycle();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
